// File: rtl/filter_inverse_pkg.sv
// Shared definitions for the filter / filter_inverse pair: defaults, FSM encoding, counter limit.
package filter_inverse_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_TAPS  = 4;
  localparam int unsigned COUNT_W   = 16;

  localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/filter_inverse_tap_history.sv
// tap_history: shift register of the last TAPS-1 recovered words plus their modulo-2^WIDTH sum.
module tap_history #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAPS  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sum
);

  localparam int unsigned DEPTH = TAPS - 1;

  logic [WIDTH-1:0] h [DEPTH];
  logic [WIDTH-1:0] sum_q;

  // h[0] is the most recent word
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) h[k] <= '0;
    end else if (shift_en) begin
      h[0] <= d;
      for (int unsigned k = 1; k < DEPTH; k++) h[k] <= h[k-1];
    end
  end

  // Running sum tracks the window incrementally, keeping the y-to-x_out path at one subtraction for any TAPS
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if (shift_en) begin
      sum_q <= sum_q + d - h[DEPTH-1];
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/filter_inverse.sv
// Streaming inverse of the moving-sum filter: x[n] = y[n] - sum of the previous TAPS-1 recovered samples.
module filter_inverse
  import filter_inverse_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned TAPS  = DEF_TAPS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   y,
  output logic [WIDTH-1:0]   x_out,
  output logic               out_valid,
  output logic [COUNT_W-1:0] count
);

  state_t           state_q;
  state_t           state_d;
  logic             accept_c;
  logic [WIDTH-1:0] hist_sum;
  logic [WIDTH-1:0] x_new_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  // The edge leaving reset only arms the block, so in_valid held through reset is ignored
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      ST_RESET: state_d  = ST_RUN;
      ST_RUN:   accept_c = in_valid;
      default:  state_d  = ST_RESET;
    endcase
  end

  assign x_new_c = y - hist_sum;

  tap_history #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_tap_history (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept_c),
    .d        (x_new_c),
    .sum      (hist_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      x_out     <= '0;
      out_valid <= 1'b0;
      count     <= '0;
    end else begin
      out_valid <= accept_c;
      if (accept_c) begin
        x_out <= x_new_c;
        if (count != COUNT_MAX) count <= count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_filter_inverse.sv
// Randomized self-checking bench: a forward moving-sum generator feeds the DUT, recovered samples are checked.
module tb_filter_inverse;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAPS  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [WIDTH-1:0]  y;
  logic [WIDTH-1:0]  x_out;
  logic              out_valid;
  logic [15:0]       count;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] pending [$];
  logic [WIDTH-1:0] fx [$];

  logic [WIDTH-1:0] exp_x   = '0;
  logic             exp_v   = 1'b0;
  logic [15:0]      exp_c   = '0;
  logic             armed   = 1'b0;
  logic             started = 1'b0;

  always #5 clk = ~clk;

  filter_inverse #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .y         (y),
    .x_out     (x_out),
    .out_valid (out_valid),
    .count     (count)
  );

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each accepted edge emits the next original sample the generator intended
  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      exp_x = '0; exp_v = 1'b0; exp_c = '0; armed = 1'b0;
    end else if (!armed) begin
      armed = 1'b1; exp_v = 1'b0;
    end else if (in_valid) begin
      if (pending.size() == 0) begin
        total++; bad++;
        $display("FAIL model_underflow at %0t", $time);
      end else begin
        exp_x = pending.pop_front();
      end
      exp_v = 1'b1;
      if (exp_c != 16'hFFFF) exp_c = exp_c + 16'd1;
    end else begin
      exp_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("x_out", x_out, exp_x);
      chk("out_valid", WIDTH'(out_valid), WIDTH'(exp_v));
      chk("count", WIDTH'(count), WIDTH'(exp_c));
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [WIDTH-1:0] yv);
    @(negedge clk);
    reset = r; in_valid = v; y = yv;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, $urandom);
  endtask

  // Forward moving sum over the intended samples
  task automatic send_x(input logic [WIDTH-1:0] xv);
    logic [WIDTH-1:0] acc;
    acc = xv;
    foreach (fx[i]) acc = acc + fx[i];
    pending.push_back(xv);
    fx.push_front(xv);
    if (fx.size() > TAPS - 1) void'(fx.pop_back());
    cyc(1'b0, 1'b1, acc);
  endtask

  task automatic send_y(input logic [WIDTH-1:0] yv, input logic [WIDTH-1:0] xe);
    pending.push_back(xe);
    cyc(1'b0, 1'b1, yv);
  endtask

  // Reset with junk valid samples, including the releasing edge which must accept nothing
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, $urandom);
    fx.delete();
    pending.delete();
    cyc(1'b0, 1'b1, $urandom);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; y = '0;
    do_reset(3);

    // Ramp through literal y values
    send_y(32'd0, 32'd0);  send_y(32'd1, 32'd1);  send_y(32'd3, 32'd2);  send_y(32'd6, 32'd3);
    send_y(32'd10, 32'd4); send_y(32'd14, 32'd5); send_y(32'd18, 32'd6); send_y(32'd22, 32'd7);
    idle();
    chk("ramp_last_x", x_out, 32'd7);
    chk("ramp_count", WIDTH'(count), 32'd8);

    // Wrap-around
    do_reset(1);
    send_y(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send_y(32'h0000_0000, 32'h0000_0001);
    send_y(32'h0000_0001, 32'h0000_0001);
    idle();
    chk("wrap_last_x", x_out, 32'h0000_0001);
    chk("wrap_count", WIDTH'(count), 32'd3);

    // Mid-stream reset after 5 ramp samples
    do_reset(1);
    for (int i = 0; i < 5; i++) send_x(WIDTH'(i));
    do_reset(2);
    chk("rst_x_out", x_out, 32'd0);
    chk("rst_count", WIDTH'(count), 32'd0);
    chk("rst_out_valid", WIDTH'(out_valid), 32'd0);
    send_y(32'd0, 32'd0); send_y(32'd1, 32'd1); send_y(32'd3, 32'd2);
    idle();
    chk("post_rst_x", x_out, 32'd2);

    // Gapped ramp (1,0,0 pattern)
    do_reset(1);
    for (int i = 0; i < 30; i++) begin
      send_x(WIDTH'(i)); idle(); idle();
    end
    chk("gap_count", WIDTH'(count), 32'd30);

    // Random data with random gaps and occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 3));
      else if ($urandom_range(0, 9) < 7) send_x($urandom);
      else idle();
    end

    // Counter saturation with continuing exact recovery
    do_reset(1);
    for (int i = 0; i < 65540; i++) send_x($urandom);
    idle();
    chk("sat_count", WIDTH'(count), 32'h0000_FFFF);
    send_x(32'hDEAD_BEEF);
    idle();
    chk("sat_x", x_out, 32'hDEAD_BEEF);
    chk("sat_hold", WIDTH'(count), 32'h0000_FFFF);

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filter_inverse.md
# filter_inverse

Streaming inverse of the team's moving-sum `filter` block. It reconstructs the original sample stream `x` from the filtered stream `y`, where `y[n] = x[n] + x[n-1] + … + x[n-TAPS+1]` modulo 2^WIDTH, with history zero after reset. It sits at the receiving end of a `filter` output, either after a channel or in a loopback bench, and recovers `x` bit-exactly. It uses a registered recursive difference over a history shift register of previously recovered samples.

## Interface
Parameters:
- `WIDTH`, 32: sample width in bits, for both input and output.
- `TAPS`, 4: number of taps in the forward moving sum; legal range 2..16.

Ports:
- `clk`  input  1: single clock; all logic is rising-edge.
- `reset`  input  1: synchronous, active-high reset.
- `in_valid`  input  1: `y` carries a new filtered sample this cycle.
- `y`  input  WIDTH: filtered sample, unsigned, interpreted modulo 2^WIDTH.
- `x_out`  output  WIDTH: recovered sample.
- `out_valid`  output  1: `x_out` is new this cycle; a one-cycle pulse per accepted input.
- `count`  output  16: number of samples recovered since reset; saturates at 0xFFFF.

## Operation
- History `h[1..TAPS-1]` holds the last TAPS-1 recovered samples, with `h[1]` the most recent.
- On a rising edge with `in_valid=1`:
  - `x_new = y - (h[1] + … + h[TAPS-1])` modulo 2^WIDTH.
  - `x_out <= x_new`, `out_valid <= 1`.
  - History shifts: `h[k] <= h[k-1]` and `h[1] <= x_new`.
  - `count` increments unless it is already 0xFFFF.
- On a rising edge with `in_valid=0`: `out_valid <= 0`. `x_out`, history and `count` hold.
- All arithmetic wraps modulo 2^WIDTH. The sum of the history is computed at WIDTH bits and its carry is discarded. There is no overflow flag.
- Warm-up needs no special state: zeroed history makes the first TAPS-1 outputs exact, e.g. `x[0]=y[0]`.
- Two-state control FSM:
  - RESET: entered while `reset=1`.
  - RUN: entered on the first edge with `reset=0`.
  - The FSM exists so that `in_valid` asserted during reset is ignored.
- Reset has priority over `in_valid` on the same edge.
- Reset mid-stream: history, `x_out` and `count` clear. The next valid `y` is treated as sample 0, which matches a forward `filter` reset on the same edge.

## Timing
- Latency: 1 cycle. `y` sampled at edge n appears on `x_out` after edge n, with `out_valid=1` during cycle n+1.
- Throughput: one sample per cycle. Back-to-back `in_valid` is fully supported.
- Gaps in `in_valid` of any length are allowed. Recovery is independent of the gap pattern.
- Reset values:
  - `x_out = 0`
  - `out_valid = 0`
  - `count = 0`
  - all history = 0
  - FSM = RESET
- First accepted sample: the first edge with `reset=0` and `in_valid=1`. An edge that deasserts `reset` accepts nothing.
- The combinational path from `y` through the history-sum subtraction to the `x_out` register must close at the target clock for TAPS=16.

## Structure
- Shared include `filter_defs.vh`: default `WIDTH`/`TAPS` defines, FSM state encodings (`ST_RESET=1'b0`, `ST_RUN=1'b1`), and `COUNT_MAX=16'hFFFF`. The forward `filter` uses the same defaults.
- Sub-module `tap_history`:
  - Parameterized shift register of TAPS-1 words.
  - Ports: `clk`, `reset`, `shift_en`, `d`, `sum`.
  - `sum` is the combinational modulo-2^WIDTH sum of all stored words.
- The top level holds the FSM, the subtractor, the output registers and the counter.

## Test plan
Benches use TAPS=4, WIDTH=32.
- **Ramp:** feed `y = 0,1,3,6,10,14,18,22` with `in_valid=1` continuously. `x_out` = 0,1,2,3,4,5,6,7 one cycle later; `count` reaches 8.
- **Loopback:** a `filter` instance is driven with the ramp `x=0,1,2,…`, and its `y` feeds this block. `x_out` equals `x` delayed by the filter latency plus 1 cycle, for 100 samples.
- **Wrap-around:** feed `y = 0xFFFFFFFF, 0x00000000, 0x00000001`. `x_out` = 0xFFFFFFFF, 0x00000001, 0x00000001.
- **Gaps:** drive the ramp with `in_valid` toggling 1,0,0,1,… `x_out` sequence is identical to the ramp case; `out_valid` pulses only after valid cycles; `x_out` holds between pulses.
- **Reset mid-stream:**
  - After 5 ramp samples, assert `reset` for 2 cycles with `in_valid=1`.
  - During reset: `x_out=0`, `out_valid=0`, `count=0`.
  - The next `y=0,1,3` gives `x_out=0,1,2`.
- **Counter saturation:** apply 65 540 valid samples. `count` stops at 0xFFFF and data recovery remains exact.
